// File: rtl/sdram_tester_pkg.sv
// Shared definitions for the SDRAM test initiator and the on-chip memory responder.
package sdram_tester_pkg;

   // Defaults shared with the test initiator so both sides agree on the bus shape.
   localparam int DEF_ADDR_WIDTH   = 24;
   localparam int DEF_DATA_WIDTH   = 16;
   localparam int DEF_BURST_LENGTH = 8;

   // Responder FSM states, exported on the debug state port.
   typedef enum logic [2:0] {
      R_IDLE    = 3'd0,
      R_WR_DATA = 3'd1,
      R_RD_WAIT = 3'd2,
      R_RD_DATA = 3'd3
   } resp_state_t;

endpackage

// File: rtl/sdram_mem_responder_if.sv
// Request/response bus between an SDRAM initiator (master) and the memory responder (slave).
//
// Handshake rule for every channel: a transfer happens on the rising clock edge where
// valid and ready are both high. Once valid is raised by the sender, the payload
// (addr/data/last) stays stable until that transfer. Ready may be high without valid;
// it is then simply ignored.
interface sdram_mem_responder_if #(
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 16
);

   logic                  writer_valid_i;
   logic                  writer_ready_o;
   logic [ADDR_WIDTH-1:0] writer_addr_i;
   logic [DATA_WIDTH-1:0] writer_data_i;

   logic                  reader_valid_i;
   logic                  reader_ready_o;
   logic [ADDR_WIDTH-1:0] reader_addr_i;

   logic                  resp_valid_o;
   logic                  resp_last_o;
   logic [DATA_WIDTH-1:0] resp_data_o;
   logic                  resp_ready_i;

   modport master (
      output writer_valid_i, writer_addr_i, writer_data_i,
      output reader_valid_i, reader_addr_i,
      output resp_ready_i,
      input  writer_ready_o, reader_ready_o,
      input  resp_valid_o, resp_last_o, resp_data_o
   );

   modport slave (
      input  writer_valid_i, writer_addr_i, writer_data_i,
      input  reader_valid_i, reader_addr_i,
      input  resp_ready_i,
      output writer_ready_o, reader_ready_o,
      output resp_valid_o, resp_last_o, resp_data_o
   );

endinterface

// File: rtl/sdram_resp_ram.sv
// Simple dual-port block RAM: one write port, one registered read port with enable.
// The read register only loads when re is high, so it doubles as the output hold
// register while the initiator stalls.
module sdram_resp_ram #(
   parameter int DATA_WIDTH = 16,
   parameter int AW         = 12
) (
   input  logic                  clk_axi,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**AW];

   // Write port.
   always_ff @(posedge clk_axi) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read port; holds its value when re is low.
   always_ff @(posedge clk_axi) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/sdram_mem_responder.sv
// On-chip memory standing in for the SDRAM controller front end: accepts write bursts
// (address beat then data beats) and read requests, returns read bursts with last.
module sdram_mem_responder
   import sdram_tester_pkg::*;
#(
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int BURST_LENGTH = DEF_BURST_LENGTH,
   parameter int MEM_DEPTH    = 4096,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk_axi,
   input  logic                  rst_axi,
   sdram_mem_responder_if.slave  bus,
   output logic [2:0]            state_o,
   output logic [15:0]           wr_bursts_o,
   output logic [15:0]           rd_bursts_o
);

   localparam int IDX_W  = $clog2(MEM_DEPTH);
   localparam int BEAT_W = $clog2(BURST_LENGTH);
   localparam int LAT_W  = 4;

   resp_state_t       state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [15:0]       wr_cnt_q, wr_cnt_d;
   logic [15:0]       rd_cnt_q, rd_cnt_d;

   logic              wr_rdy, rd_rdy, rsp_vld, rsp_last;
   logic              ram_we, ram_re;
   logic [IDX_W-1:0]  ram_waddr, ram_raddr;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic              last_beat;

   // Address bits above the memory index are deliberately ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.writer_addr_i[ADDR_WIDTH-1:IDX_W],
                               bus.reader_addr_i[ADDR_WIDTH-1:IDX_W]};

   assign last_beat = (beat_q == BEAT_W'(BURST_LENGTH - 1));

   // State and datapath registers; memory contents are left untouched by reset.
   always_ff @(posedge clk_axi) begin
      if (rst_axi) begin
         state_q  <= R_IDLE;
         idx_q    <= '0;
         beat_q   <= '0;
         lat_q    <= '0;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         beat_q   <= beat_d;
         lat_q    <= lat_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
      end
   end

   // Next state, handshakes and RAM control. In R_RD_DATA the RAM is read one beat
   // ahead only when the current beat is taken, so the read register is the prefetch.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      beat_d    = beat_q;
      lat_d     = lat_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      wr_rdy    = 1'b0;
      rd_rdy    = 1'b0;
      rsp_vld   = 1'b0;
      rsp_last  = 1'b0;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_waddr = idx_q + IDX_W'(beat_q);
      ram_raddr = idx_q + IDX_W'(beat_q);
      case (state_q)
         R_IDLE: begin
            wr_rdy = 1'b1;
            rd_rdy = !bus.writer_valid_i;
            if (bus.writer_valid_i) begin
               idx_d   = bus.writer_addr_i[IDX_W-1:0];
               beat_d  = '0;
               state_d = R_WR_DATA;
            end else if (bus.reader_valid_i) begin
               idx_d   = bus.reader_addr_i[IDX_W-1:0];
               beat_d  = '0;
               lat_d   = LAT_W'(READ_LATENCY - 1);
               state_d = R_RD_WAIT;
            end
         end
         R_WR_DATA: begin
            wr_rdy = 1'b1;
            if (bus.writer_valid_i) begin
               ram_we = 1'b1;
               beat_d = beat_q + 1'b1;
               if (last_beat) begin
                  wr_cnt_d = wr_cnt_q + 16'd1;
                  state_d  = R_IDLE;
               end
            end
         end
         R_RD_WAIT: begin
            ram_re = 1'b1;
            if (lat_q == '0) state_d = R_RD_DATA;
            else             lat_d   = lat_q - 1'b1;
         end
         R_RD_DATA: begin
            rsp_vld   = 1'b1;
            rsp_last  = last_beat;
            ram_raddr = idx_q + IDX_W'(beat_q) + IDX_W'(1);
            if (bus.resp_ready_i) begin
               ram_re = 1'b1;
               beat_d = beat_q + 1'b1;
               if (last_beat) begin
                  rd_cnt_d = rd_cnt_q + 16'd1;
                  state_d  = R_IDLE;
               end
            end
         end
         default: state_d = R_IDLE;
      endcase
   end

   // Every output is forced low while reset is asserted, even mid-burst.
   always_comb begin
      bus.writer_ready_o = wr_rdy   && !rst_axi;
      bus.reader_ready_o = rd_rdy   && !rst_axi;
      bus.resp_valid_o   = rsp_vld  && !rst_axi;
      bus.resp_last_o    = rsp_last && !rst_axi;
      bus.resp_data_o    = (rsp_vld && !rst_axi) ? ram_rdata : '0;
      state_o            = rst_axi ? R_IDLE : state_q;
      wr_bursts_o        = rst_axi ? 16'd0 : wr_cnt_q;
      rd_bursts_o        = rst_axi ? 16'd0 : rd_cnt_q;
   end

   sdram_resp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .AW         (IDX_W)
   ) u_ram (
      .clk_axi (clk_axi),
      .we      (ram_we && !rst_axi),
      .waddr   (ram_waddr),
      .wdata   (bus.writer_data_i),
      .re      (ram_re),
      .raddr   (ram_raddr),
      .rdata   (ram_rdata)
   );

endmodule
